// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - digit scan bus between the value source/display and seg_scan
//
// Purpose: groups the value/control inputs and the scan outputs of seg_scan.
// Signals:
//   val_i      source -> scanner  packed hex value, digit k = val_i[4k+3:4k]
//   load       source -> scanner  1-cycle capture strobe for val_i
//   en         source -> scanner  scan enable, low = dark and frozen
//   nibble     scanner -> display current digit value for the segment decoder
//   an         scanner -> display active-low digit enables
//   digit_idx  scanner -> display index of the digit being driven
//   frame      scanner -> display 1-cycle pulse when the index wraps to 0
// Modports: master (drives val_i/load/en), slave (the scanner).
interface seg_scan_if #(
  parameter int DIGITS = 8,
  parameter int IW     = $clog2(DIGITS)
);
  logic [4*DIGITS-1:0] val_i;
  logic                load;
  logic                en;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   an;
  logic [IW-1:0]       digit_idx;
  logic                frame;

  modport master (
    output val_i, load, en,
    input  nibble, an, digit_idx, frame
  );

  modport slave (
    input  val_i, load, en,
    output nibble, an, digit_idx, frame
  );
endinterface

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed 7-segment digit scan driver
//
// Purpose: captures a packed hex value into a shadow register and steps through one
// digit per DIV clock cycles, presenting that digit's nibble and an active-low enable.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-high reset
//   bus   seg_scan_if.slave: val_i, load, en in; nibble, an, digit_idx, frame out
// Configuration:
//   SEG_SCAN_LZB_EN  when defined, leading zero digits (k>0) are blanked on an.
module seg_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 1000,
  parameter int IW     = $clog2(DIGITS)
) (
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.slave bus
);

  localparam int CW = $clog2(DIV);
  localparam int VW = 4 * DIGITS;

  logic [VW-1:0]     shadow_q, shadow_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        nibble_q, nibble_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_q, frame_d;

  logic              tick;
  logic              wrap;
  logic [DIGITS-1:0] lit_mask;
  logic [DIGITS-1:0] blank_mask;
  logic              zeros_above;

  assign tick = bus.en && (cnt_q == CW'(DIV - 1));
  assign wrap = (idx_q == IW'(DIGITS - 1));

  // Outputs are built from the next state so that a load and a tick landing on the
  // same edge are both visible in the very next output cycle.
  always_comb begin
    shadow_d    = bus.load ? bus.val_i : shadow_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    nibble_d    = 4'h0;
    lit_mask    = '0;
    blank_mask  = '0;
    zeros_above = 1'b1;

    if (bus.en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    frame_d = tick && wrap;

    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nibble_d    = shadow_d[4*k +: 4];
        lit_mask[k] = 1'b1;
      end
    end

`ifdef SEG_SCAN_LZB_EN
    // Walk down from the top digit; a digit is blank while everything at or above
    // it is zero. Digit 0 is left out so a zero value still shows "0".
    for (int k = DIGITS - 1; k > 0; k--) begin
      zeros_above   = zeros_above && (shadow_d[4*k +: 4] == 4'h0);
      blank_mask[k] = zeros_above;
    end
`else
    blank_mask  = '0;
    zeros_above = 1'b0;
`endif

    an_d = bus.en ? ~(lit_mask & ~blank_mask) : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      nibble_q <= 4'h0;
      an_q     <= '1;
      frame_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      nibble_q <= nibble_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.nibble    = nibble_q;
  assign bus.an        = an_q;
  // idx_q is itself the registered index, updated on the same edge as nibble/an.
  assign bus.digit_idx = idx_q;
  assign bus.frame     = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan (DIGITS=4, DIV=4)
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic [15:0] val = 16'h0;

  int compared = 0;
  int mismatched = 0;

  seg_scan_if #(.DIGITS(4), .IW(2)) bus ();

  assign bus.val_i = val;
  assign bus.load  = load;
  assign bus.en    = en;

  seg_scan #(.DIGITS(4), .DIV(4), .IW(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: position in the scan is the number of enabled edges since reset.
  int          n = 0;
  logic [15:0] m_shadow = 16'h0;
  bit          m_lit = 0;
  bit          m_frame = 0;
  logic [1:0]  exp_idx;
  logic [3:0]  exp_nibble;
  logic [3:0]  exp_an;

  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      n = 0; m_shadow = 16'h0; m_lit = 0; m_frame = 0;
    end else begin
      if (load) m_shadow = val;
      if (en) n++;
      m_lit   = en;
      m_frame = en && (n % 16 == 0);
    end
    exp_idx    = 2'((n / 4) % 4);
    exp_nibble = 4'(m_shadow >> (4 * exp_idx));
    exp_an     = 4'b1111;
    if (m_lit) begin
      exp_an[exp_idx] = 1'b0;
`ifdef SEG_SCAN_LZB_EN
      for (int k = 1; k < 4; k++)
        if ((m_shadow >> (4 * k)) == 16'h0) exp_an[k] = 1'b1;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; load = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      compared++;
      if ({bus.nibble, bus.an, bus.digit_idx, bus.frame} !== {4'h0, 4'b1111, 2'd0, 1'b0}) begin
        mismatched++;
        $display("FAIL reset_hold: got nib=%h an=%b idx=%0d fr=%b, want nib=0 an=1111 idx=0 fr=0",
                 bus.nibble, bus.an, bus.digit_idx, bus.frame);
      end
    end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      compared++;
      if ({bus.nibble, bus.an, bus.digit_idx, bus.frame} !== {4'h0, 4'b1111, 2'd0, 1'b0}) begin
        mismatched++;
        $display("FAIL reset_release_en0: got nib=%h an=%b idx=%0d fr=%b, want nib=0 an=1111 idx=0 fr=0",
                 bus.nibble, bus.an, bus.digit_idx, bus.frame);
      end
    end
  endtask

  task automatic test_scan();
    int frames = 0;
    int last_frame = -1;
    val = 16'h1A2F; load = 1; en = 1;
    cycle();
    load = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) cycle();
      compared++;
      if ({bus.nibble, bus.an, bus.digit_idx, bus.frame} !== {exp_nibble, exp_an, exp_idx, m_frame}) begin
        mismatched++;
        $display("FAIL scan: got nib=%h an=%b idx=%0d fr=%b, want nib=%h an=%b idx=%0d fr=%b",
                 bus.nibble, bus.an, bus.digit_idx, bus.frame, exp_nibble, exp_an, exp_idx, m_frame);
      end
      if (bus.frame === 1'b1) begin
        if (last_frame >= 0) begin
          compared++;
          if (i - last_frame != 16) begin
            mismatched++;
            $display("FAIL frame_period: got %0d, want 16", i - last_frame);
          end
        end
        last_frame = i;
        frames++;
      end
    end
    // 40 enabled edges starting at edge 1: wraps at edges 16 and 32.
    compared++;
    if (frames != 2) begin
      mismatched++;
      $display("FAIL frame_count: got %0d, want 2", frames);
    end
  endtask

  task automatic test_load_on_tick();
    en = 1;
    for (int i = 0; i < 32 && (n % 16 != 7); i++) cycle();
    compared++;
    if (n % 16 != 7) begin
      mismatched++;
      $display("FAIL load_tick_reach: got pos=%0d, want 7", n % 16);
    end
    val = 16'h0000; load = 1;
    cycle();
    load = 0;
    compared++;
    if ({bus.an, bus.nibble, bus.digit_idx} !== {4'b1011, 4'h0, 2'd2}) begin
      mismatched++;
      $display("FAIL load_on_tick: got an=%b nib=%h idx=%0d, want an=1011 nib=0 idx=2",
               bus.an, bus.nibble, bus.digit_idx);
    end
    val = 16'h1A2F; load = 1;
    cycle();
    load = 0;
    compared++;
    if ({bus.nibble, bus.an} !== {exp_nibble, exp_an}) begin
      mismatched++;
      $display("FAIL reload: got nib=%h an=%b, want nib=%h an=%b", bus.nibble, bus.an, exp_nibble, exp_an);
    end
  endtask

  task automatic test_en_pause();
    int run1 = 0;
    en = 1;
    for (int i = 0; i < 32 && (n % 16 != 5); i++) cycle();
    en = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      compared++;
      if ({bus.an, bus.digit_idx} !== {4'b1111, 2'd1}) begin
        mismatched++;
        $display("FAIL en_pause: got an=%b idx=%0d, want an=1111 idx=1", bus.an, bus.digit_idx);
      end
    end
    en = 1;
    for (int i = 0; i < 8 && bus.digit_idx === 2'd1; i++) begin
      cycle();
      if (bus.digit_idx === 2'd1) run1++;
      compared++;
      if ({bus.nibble, bus.an, bus.digit_idx} !== {exp_nibble, exp_an, exp_idx}) begin
        mismatched++;
        $display("FAIL en_resume: got nib=%h an=%b idx=%0d, want nib=%h an=%b idx=%0d",
                 bus.nibble, bus.an, bus.digit_idx, exp_nibble, exp_an, exp_idx);
      end
    end
    // Paused at cnt=1 of digit 1: two more edges stay on digit 1.
    compared++;
    if (run1 != 2) begin
      mismatched++;
      $display("FAIL en_resume_len: got %0d, want 2", run1);
    end
  endtask

  task automatic test_reset_mid();
    en = 1;
    for (int i = 0; i < 32 && exp_idx != 2'd3; i++) cycle();
    rst = 1;
    cycle();
    rst = 0;
    compared++;
    if ({bus.an, bus.digit_idx, bus.nibble, bus.frame} !== {4'b1111, 2'd0, 4'h0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_mid: got an=%b idx=%0d nib=%h fr=%b, want an=1111 idx=0 nib=0 fr=0",
               bus.an, bus.digit_idx, bus.nibble, bus.frame);
    end
    for (int i = 0; i < 20; i++) begin
      cycle();
      compared++;
      if ({bus.nibble, bus.an, bus.digit_idx, bus.frame} !== {exp_nibble, exp_an, exp_idx, m_frame}) begin
        mismatched++;
        $display("FAIL reset_restart: got nib=%h an=%b idx=%0d fr=%b, want nib=%h an=%b idx=%0d fr=%b",
                 bus.nibble, bus.an, bus.digit_idx, bus.frame, exp_nibble, exp_an, exp_idx, m_frame);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 15) == 0);
      val  = 16'($urandom);
      rst  = ($urandom_range(0, 99) == 0);
      cycle();
      compared++;
      if ({bus.nibble, bus.an, bus.digit_idx, bus.frame} !== {exp_nibble, exp_an, exp_idx, m_frame}) begin
        mismatched++;
        $display("FAIL random[%0d]: got nib=%h an=%b idx=%0d fr=%b, want nib=%h an=%b idx=%0d fr=%b",
                 i, bus.nibble, bus.an, bus.digit_idx, bus.frame, exp_nibble, exp_an, exp_idx, m_frame);
      end
    end
    rst = 0; load = 0;
  endtask

`ifdef SEG_SCAN_LZB_EN
  task automatic test_lzb();
    en = 1; val = 16'h0012; load = 1;
    cycle();
    load = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cycle();
      compared++;
      if (bus.an[3:2] !== 2'b11 || {bus.an, bus.nibble} !== {exp_an, exp_nibble}) begin
        mismatched++;
        $display("FAIL lzb_0012: got an=%b nib=%h, want an=%b nib=%h", bus.an, bus.nibble, exp_an, exp_nibble);
      end
    end
    val = 16'h0000; load = 1;
    cycle();
    load = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cycle();
      compared++;
      if (bus.nibble !== 4'h0 || !(bus.an === 4'b1110 || bus.an === 4'b1111) || bus.an !== exp_an) begin
        mismatched++;
        $display("FAIL lzb_0000: got an=%b nib=%h, want an=%b nib=0", bus.an, bus.nibble, exp_an);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_load_on_tick();
    test_en_pause();
    test_reset_mid();
`ifdef SEG_SCAN_LZB_EN
    test_lzb();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
